// File: rtl/zigzag_rle_encoder_pkg.sv
// Shared constants for the zigzag encoder/normaliser pair.
//   - Width macros (PIXEL_BIT, BLOCK_BIT, BLOCK_AREA, BLOCK_AREA_BIT,
//     RUN_BIT, CAT_BIT, HIGH, LOW), defined here only if not already set.
//   - ZZ_FWD: zigzag index -> raster index (row*8+col).
//   - zz_inverse(): raster index -> zigzag index, derived from ZZ_FWD so
//     both directions come from a single table.
//   - state_e: encoder states.
`ifndef PIXEL_BIT
`define PIXEL_BIT 12
`endif
`ifndef BLOCK_BIT
`define BLOCK_BIT 3
`endif
`ifndef BLOCK_AREA
`define BLOCK_AREA 64
`endif
`ifndef BLOCK_AREA_BIT
`define BLOCK_AREA_BIT 6
`endif
`ifndef RUN_BIT
`define RUN_BIT 4
`endif
`ifndef CAT_BIT
`define CAT_BIT 11
`endif
`ifndef HIGH
`define HIGH 1'b1
`endif
`ifndef LOW
`define LOW 1'b0
`endif

package zigzag_rle_encoder_pkg;

   typedef enum logic {
      YAZ  = 1'b0,
      TARA = 1'b1
   } state_e;

   localparam logic [`BLOCK_AREA_BIT-1:0] ZZ_FWD [`BLOCK_AREA] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   function automatic logic [`BLOCK_AREA_BIT-1:0] zz_inverse(
      input logic [`BLOCK_AREA_BIT-1:0] raster);
      logic [`BLOCK_AREA_BIT-1:0] idx;
      idx = '0;
      for (int i = 0; i < `BLOCK_AREA; i++) begin
         if (ZZ_FWD[i] == raster) idx = i[`BLOCK_AREA_BIT-1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/zigzag_rle_encoder_scan_rom.sv
// zigzag_scan_rom: combinational zigzag lookup.
//   zz_idx_i -> raster_o : forward map used by the scan.
//   raster_i -> zz_idx_o : inverse map, present only when ZIGZAG_EOB_EN is
//                          defined (needed for last-nonzero tracking).
module zigzag_scan_rom
   import zigzag_rle_encoder_pkg::*;
(
   input  logic [`BLOCK_AREA_BIT-1:0] zz_idx_i,
   output logic [`BLOCK_AREA_BIT-1:0] raster_o
`ifdef ZIGZAG_EOB_EN
   ,
   input  logic [`BLOCK_AREA_BIT-1:0] raster_i,
   output logic [`BLOCK_AREA_BIT-1:0] zz_idx_o
`endif
);

   assign raster_o = ZZ_FWD[zz_idx_i];
`ifdef ZIGZAG_EOB_EN
   assign zz_idx_o = zz_inverse(raster_i);
`endif

endmodule

// File: rtl/zigzag_rle_encoder.sv
// zigzag_rle_encoder: buffers one 8x8 coefficient block written by
// (row, col), then scans it in zigzag order emitting (run, value) pairs.
//   clk_i, rstn_i (sync, active-low)
//   ct_*  : coefficient write side (valid/ready, last-of-block flag)
//   hd_*  : registered (run, value) output toward the Huffman encoder
// Optional macro ZIGZAG_EOB_EN: track the last nonzero zigzag index and end
// the block early with a single EOB (0,0).
//
// state | meaning
// YAZ   | accepting coefficient writes into the block buffer
// TARA  | zigzag scan, emitting pairs; input stalled
module zigzag_rle_encoder
   import zigzag_rle_encoder_pkg::*;
#(
   parameter int unsigned MAX_RUN = 15
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [`PIXEL_BIT-1:0] ct_veri_i,
   input  logic [`BLOCK_BIT-1:0] ct_row_i,
   input  logic [`BLOCK_BIT-1:0] ct_col_i,
   input  logic                  ct_gecerli_i,
   input  logic                  ct_blok_son_i,
   output logic                  ct_hazir_o,
   output logic [`RUN_BIT-1:0]   hd_run_o,
   output logic [`CAT_BIT-1:0]   hd_cat_o,
   output logic                  hd_gecerli_o,
   output logic                  hd_blok_son_o,
   input  logic                  hd_hazir_i
);

   localparam logic [`RUN_BIT-1:0]        MAX_RUN_V = MAX_RUN[`RUN_BIT-1:0];
   localparam logic [`BLOCK_AREA_BIT-1:0] K_LAST    = `BLOCK_AREA_BIT'(`BLOCK_AREA - 1);

   state_e                      state_q, state_d;
   logic [`PIXEL_BIT-1:0]       buf_q [`BLOCK_AREA];
   logic [`BLOCK_AREA_BIT-1:0]  k_q, k_d;
   logic [`RUN_BIT-1:0]         run_q, run_d;
   logic                        out_vld_q, out_vld_d;
   logic [`RUN_BIT-1:0]         out_run_q, out_run_d;
   logic [`CAT_BIT-1:0]         out_cat_q, out_cat_d;
   logic                        out_last_q, out_last_d;

   logic [`BLOCK_AREA_BIT-1:0]  wr_addr, rd_addr;
   logic [`PIXEL_BIT-1:0]       coef;
   logic                        wr_en, rd_clr, buf_clr_all, adv, eob_hit;

   assign wr_addr    = {ct_row_i, ct_col_i};
   assign ct_hazir_o = (state_q == YAZ);
   assign wr_en      = ct_gecerli_i && ct_hazir_o;
   assign coef       = buf_q[rd_addr];
   // Scan advances only when the output register is free this cycle.
   assign adv        = (state_q == TARA) && (!out_vld_q || hd_hazir_i);

`ifdef ZIGZAG_EOB_EN
   logic [`BLOCK_AREA_BIT-1:0] wr_zz, l_q, l_d;
   logic                       l_vld_q, l_vld_d;

   zigzag_scan_rom u_rom (
      .zz_idx_i (k_q),
      .raster_o (rd_addr),
      .raster_i (wr_addr),
      .zz_idx_o (wr_zz)
   );

   // L==63 can never satisfy k>L, so that case falls through to the full scan.
   assign eob_hit = !l_vld_q || (k_q > l_q);

   always_comb begin
      l_d     = l_q;
      l_vld_d = l_vld_q;
      if (wr_en && (ct_veri_i != '0) && (!l_vld_q || (wr_zz > l_q))) begin
         l_d     = wr_zz;
         l_vld_d = 1'b1;
      end
      if ((state_q == TARA) && (state_d == YAZ)) begin
         l_d     = '0;
         l_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         l_q     <= '0;
         l_vld_q <= 1'b0;
      end else begin
         l_q     <= l_d;
         l_vld_q <= l_vld_d;
      end
   end
`else
   zigzag_scan_rom u_rom (
      .zz_idx_i (k_q),
      .raster_o (rd_addr)
   );

   assign eob_hit = `LOW;
`endif

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      run_d       = run_q;
      out_vld_d   = out_vld_q;
      out_run_d   = out_run_q;
      out_cat_d   = out_cat_q;
      out_last_d  = out_last_q;
      rd_clr      = 1'b0;
      buf_clr_all = 1'b0;

      if (out_vld_q && hd_hazir_i) out_vld_d = 1'b0;

      if (state_q == YAZ) begin
         if (wr_en && ct_blok_son_i) state_d = TARA;
      end else if (adv) begin
         if (eob_hit) begin
            out_vld_d   = 1'b1;
            out_run_d   = '0;
            out_cat_d   = '0;
            out_last_d  = 1'b1;
            buf_clr_all = 1'b1;
            state_d     = YAZ;
            k_d         = '0;
            run_d       = '0;
         end else begin
            rd_clr = 1'b1;
            k_d    = k_q + 1'b1;
            if (k_q == K_LAST) begin
               // Final position always produces a pair, even for a zero.
               out_vld_d  = 1'b1;
               out_run_d  = run_q;
               out_cat_d  = coef[`CAT_BIT-1:0];
               out_last_d = 1'b1;
               state_d    = YAZ;
               k_d        = '0;
               run_d      = '0;
            end else if (coef != '0) begin
               out_vld_d  = 1'b1;
               out_run_d  = run_q;
               out_cat_d  = coef[`CAT_BIT-1:0];
               out_last_d = 1'b0;
               run_d      = '0;
            end else if (run_q == MAX_RUN_V) begin
               out_vld_d  = 1'b1;
               out_run_d  = MAX_RUN_V;
               out_cat_d  = '0;
               out_last_d = 1'b0;
               run_d      = '0;
            end else begin
               run_d = run_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q    <= YAZ;
         k_q        <= '0;
         run_q      <= '0;
         out_vld_q  <= 1'b0;
         out_run_q  <= '0;
         out_cat_q  <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         run_q      <= run_d;
         out_vld_q  <= out_vld_d;
         out_run_q  <= out_run_d;
         out_cat_q  <= out_cat_d;
         out_last_q <= out_last_d;
      end
   end

   // Writes happen only in YAZ and read-clears only in TARA, so they never collide.
   always_ff @(posedge clk_i) begin
      if (!rstn_i || buf_clr_all) begin
         for (int i = 0; i < `BLOCK_AREA; i++) buf_q[i] <= '0;
      end else begin
         if (wr_en)  buf_q[wr_addr] <= ct_veri_i;
         if (rd_clr) buf_q[rd_addr] <= '0;
      end
   end

   assign hd_gecerli_o  = out_vld_q;
   assign hd_run_o      = out_run_q;
   assign hd_cat_o      = out_cat_q;
   assign hd_blok_son_o = out_last_q;

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
`ifndef PIXEL_BIT
`define PIXEL_BIT 12
`endif
`ifndef BLOCK_BIT
`define BLOCK_BIT 3
`endif
`ifndef RUN_BIT
`define RUN_BIT 4
`endif
`ifndef CAT_BIT
`define CAT_BIT 11
`endif

module tb_zigzag_rle_encoder;

   logic                  clk = 1'b0;
   logic                  rstn_i;
   logic [`PIXEL_BIT-1:0] ct_veri_i;
   logic [`BLOCK_BIT-1:0] ct_row_i, ct_col_i;
   logic                  ct_gecerli_i, ct_blok_son_i, ct_hazir_o;
   logic [`RUN_BIT-1:0]   hd_run_o;
   logic [`CAT_BIT-1:0]   hd_cat_o;
   logic                  hd_gecerli_o, hd_blok_son_o, hd_hazir_i;

   zigzag_rle_encoder #(.MAX_RUN(15)) dut (
      .clk_i         (clk),
      .rstn_i        (rstn_i),
      .ct_veri_i     (ct_veri_i),
      .ct_row_i      (ct_row_i),
      .ct_col_i      (ct_col_i),
      .ct_gecerli_i  (ct_gecerli_i),
      .ct_blok_son_i (ct_blok_son_i),
      .ct_hazir_o    (ct_hazir_o),
      .hd_run_o      (hd_run_o),
      .hd_cat_o      (hd_cat_o),
      .hd_gecerli_o  (hd_gecerli_o),
      .hd_blok_son_o (hd_blok_son_o),
      .hd_hazir_i    (hd_hazir_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [`RUN_BIT-1:0] run;
      logic [`CAT_BIT-1:0] cat;
      logic                last;
   } pair_t;

   pair_t got_q[$];
   pair_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Output monitor: records transfers, checks hold-stability under back-pressure.
   logic  stall_prev = 1'b0;
   pair_t prev_p;
   always @(negedge clk) begin
      if (!rstn_i) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", int'(hd_gecerli_o), 1);
            check("hold_run", int'(hd_run_o), int'(prev_p.run));
            check("hold_cat", int'(hd_cat_o), int'(prev_p.cat));
            check("hold_last", int'(hd_blok_son_o), int'(prev_p.last));
         end
         if (hd_gecerli_o && hd_hazir_i)
            got_q.push_back('{hd_run_o, hd_cat_o, hd_blok_son_o});
         stall_prev = hd_gecerli_o && !hd_hazir_i;
         prev_p     = '{hd_run_o, hd_cat_o, hd_blok_son_o};
      end
   end

   function automatic void ex(input int run, input int cat, input bit last);
      exp_q.push_back('{run[`RUN_BIT-1:0], cat[`CAT_BIT-1:0], last});
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic put(input int row, input int col, input int val, input bit last);
      int w = 0;
      ct_row_i      = row[`BLOCK_BIT-1:0];
      ct_col_i      = col[`BLOCK_BIT-1:0];
      ct_veri_i     = val[`PIXEL_BIT-1:0];
      ct_blok_son_i = last;
      ct_gecerli_i  = 1'b1;
      do begin
         @(negedge clk);
         w++;
      end while (!ct_hazir_o && w < 300);
      if (!ct_hazir_o) check("put_ready_timeout", int'(ct_hazir_o), 1);
      @(posedge clk);
      #1;
      ct_gecerli_i  = 1'b0;
      ct_blok_son_i = 1'b0;
   endtask

   task automatic wait_last(input string name);
      int w    = 0;
      bit done = 1'b0;
      while (!done && w < 1000) begin
         @(negedge clk);
         w++;
         if (got_q.size() > 0 && got_q[$].last) done = 1'b1;
      end
      check({name, "_done"}, int'(done), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic compare(input string name);
      check({name, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) begin
            check($sformatf("%s[%0d].run", name, i), int'(got_q[i].run), int'(exp_q[i].run));
            check($sformatf("%s[%0d].cat", name, i), int'(got_q[i].cat), int'(exp_q[i].cat));
            check($sformatf("%s[%0d].last", name, i), int'(got_q[i].last), int'(exp_q[i].last));
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   function automatic int coverage_sum();
      int s = 0;
      foreach (got_q[i]) s += int'(got_q[i].run) + 1;
      return s;
   endfunction

   initial begin
      rstn_i        = 1'b0;
      ct_veri_i     = '0;
      ct_row_i      = '0;
      ct_col_i      = '0;
      ct_gecerli_i  = 1'b0;
      ct_blok_son_i = 1'b0;
      hd_hazir_i    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ct_hazir", int'(ct_hazir_o), 1);
      check("rst_hd_gecerli", int'(hd_gecerli_o), 0);
      check("rst_hd_run", int'(hd_run_o), 0);
      check("rst_hd_cat", int'(hd_cat_o), 0);
      check("rst_hd_blok_son", int'(hd_blok_son_o), 0);
      @(posedge clk);
      #1;
      rstn_i = 1'b1;
      @(posedge clk);
      #1;

      // A: only (0,0)=5
      put(0, 0, 5, 1'b1);
      @(negedge clk);
      check("A_lat_not_yet", int'(hd_gecerli_o), 0);
      @(negedge clk);
      check("A_lat_first", int'(hd_gecerli_o), 1);
      @(posedge clk);
      #1;
      wait_last("A");
`ifdef ZIGZAG_EOB_EN
      ex(0, 5, 0); ex(0, 0, 1);
`else
      check("A_cover64", coverage_sum(), 64);
      ex(0, 5, 0); ex(15, 0, 0); ex(15, 0, 0); ex(15, 0, 0); ex(14, 0, 1);
`endif
      compare("A");

      // B: (0,1) written twice (last write wins), (1,0)=-2 ends the block
      put(0, 1, 9, 1'b0);
      put(0, 1, 3, 1'b0);
      put(1, 0, -2, 1'b1);
      @(negedge clk);
      check("B_ct_hazir_scan0", int'(ct_hazir_o), 0);
      repeat (20) @(negedge clk);
      check("B_ct_hazir_scan20", int'(ct_hazir_o), 0);
      @(posedge clk);
      #1;
      wait_last("B");
`ifdef ZIGZAG_EOB_EN
      ex(1, 3, 0); ex(0, 2046, 0); ex(0, 0, 1);
`else
      check("B_cover64", coverage_sum(), 64);
      ex(1, 3, 0); ex(0, 2046, 0); ex(15, 0, 0); ex(15, 0, 0); ex(15, 0, 0); ex(12, 0, 1);
`endif
      compare("B");

      // C: nonzero only at zigzag 63
      put(7, 7, 9, 1'b1);
      wait_last("C");
      ex(15, 0, 0); ex(15, 0, 0); ex(15, 0, 0); ex(15, 9, 1);
      compare("C");

      // D: reset during the scan of a row-0 block
      for (int c = 0; c < 8; c++) put(0, c, 7, c == 7);
      begin
         int w = 0;
         while (got_q.size() < 1 && w < 200) begin
            @(negedge clk);
            w++;
         end
         check("D_scan_started", int'(got_q.size() >= 1), 1);
      end
      @(posedge clk);
      #1;
      rstn_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("D_rst_ct_hazir", int'(ct_hazir_o), 1);
      check("D_rst_hd_gecerli", int'(hd_gecerli_o), 0);
      @(posedge clk);
      #1;
      rstn_i = 1'b1;
      got_q.delete();
      @(posedge clk);
      #1;

      // F: all-zero block right after the reset; stale row-0 data would show
      put(3, 3, 0, 1'b1);
      wait_last("F");
`ifdef ZIGZAG_EOB_EN
      ex(0, 0, 1);
`else
      ex(15, 0, 0); ex(15, 0, 0); ex(15, 0, 0); ex(15, 0, 1);
`endif
      compare("F");

      // E: all-ones block with a 10-cycle downstream stall mid-scan
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            put(r, c, 1, (r == 7) && (c == 7));
      begin
         int w = 0;
         while (got_q.size() < 5 && w < 200) begin
            @(negedge clk);
            w++;
         end
         check("E_pre_stall_pairs", int'(got_q.size() >= 5), 1);
      end
      @(posedge clk);
      #1;
      hd_hazir_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      hd_hazir_i = 1'b1;
      wait_last("E");
      for (int i = 0; i < 64; i++) ex(0, 1, i == 63);
      compare("E");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
